zet_front_prefetch_umi_q: RTL and testbench

ZET_FRONT_PREFETCH_UMI_Q -- requirements
Module: zet_front_prefetch_umi_q

---
 rtl/zet_front_prefetch_umi_q.sv | 179 +++++++++++++++++
 tb/tb_zet_front_prefetch_umi_q.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/zet_front_prefetch_umi_q.sv
// rtl/zet_front_prefetch_umi_q.sv - instruction prefetch queue fed from a UMI-style fetch port
//
// Fetches code bytes/words at cs:ip and queues them with their cs/ip tag.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   umi_adr_o/stb_o/by_o fetch request (byte address, strobe, byte/word)
//   umi_dat_i/ack_i     fetch response
//   flush, load_cs_ip   redirect: drop queue and in-flight fetch, reload cs/ip
//   requested_cs/ip     redirect target
//   q_valid_o, q_dat_o, q_by_o, q_cs_o, q_ip_o  queue head
//   q_rd_i              pop head
//   level_o             number of queued entries
module zet_front_prefetch_umi_q #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_CS = 16'hf000,
  parameter logic [15:0] RESET_IP = 16'hfff0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [19:0]              umi_adr_o,
  input  logic [15:0]              umi_dat_i,
  output logic                     umi_stb_o,
  output logic                     umi_by_o,
  input  logic                     umi_ack_i,
  input  logic                     flush,
  input  logic                     load_cs_ip,
  input  logic [15:0]              requested_cs,
  input  logic [15:0]              requested_ip,
  output logic                     q_valid_o,
  output logic [15:0]              q_dat_o,
  output logic                     q_by_o,
  output logic [15:0]              q_cs_o,
  output logic [15:0]              q_ip_o,
  input  logic                     q_rd_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]    state, state_n;
  logic          stb, stb_n;
  logic [15:0]   cs, cs_n, ip, ip_n;
  logic [19:0]   adr, adr_n;
  logic          by;
  logic          hold_adr;
  logic [AW:0]   count, count_after;
  logic [AW-1:0] rd_ptr, wr_ptr;

  logic [15:0]   mem_dat [DEPTH];
  logic          mem_by  [DEPTH];
  logic [15:0]   mem_cs  [DEPTH];
  logic [15:0]   mem_ip  [DEPTH];

  logic redirect, push, pop;

  assign redirect = flush | load_cs_ip;
  assign push     = (state == FETCH) && umi_ack_i && !redirect;
  assign pop      = q_rd_i && (count != '0) && !redirect;

  // Level the queue will hold after this cycle's push; decides whether the
  // strobe can stay up for another back-to-back fetch.
  always_comb begin
    count_after = count + (AW+1)'(1);
    if (pop) count_after = count;
  end

  always_comb begin
    state_n  = state;
    stb_n    = stb;
    cs_n     = cs;
    ip_n     = ip;
    hold_adr = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && (count < DEPTH_L)) begin
          state_n = FETCH;
          stb_n   = 1'b1;
        end
      end
      FETCH: begin
        if (redirect) begin
          if (umi_ack_i) begin
            state_n = IDLE;
            stb_n   = 1'b0;
          end else begin
            // Bus cycle already started: keep it intact until it completes.
            state_n  = DRAIN;
            hold_adr = 1'b1;
          end
        end else if (umi_ack_i) begin
          ip_n = ip + (ip[0] ? 16'd1 : 16'd2);
          if (count_after >= DEPTH_L) begin
            state_n = IDLE;
            stb_n   = 1'b0;
          end
        end else begin
          hold_adr = 1'b1;
        end
      end
      DRAIN: begin
        if (umi_ack_i) begin
          state_n = IDLE;
          stb_n   = 1'b0;
        end else begin
          hold_adr = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        stb_n   = 1'b0;
      end
    endcase
    if (redirect) begin
      cs_n = requested_cs;
      ip_n = requested_ip;
    end
  end

  assign adr_n = {cs_n, 4'h0} + {4'h0, ip_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      stb    <= 1'b0;
      cs     <= RESET_CS;
      ip     <= RESET_IP;
      adr    <= {RESET_CS, 4'h0} + {4'h0, RESET_IP};
      by     <= RESET_IP[0];
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_n;
      stb   <= stb_n;
      cs    <= cs_n;
      ip    <= ip_n;
      if (!hold_adr) begin
        adr <= adr_n;
        by  <= ip_n[0];
      end
      if (redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + (AW+1)'(1);
        else if (pop && !push) count <= count - (AW+1)'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= by ? {8'h00, umi_dat_i[7:0]} : umi_dat_i;
      mem_by[wr_ptr]  <= by;
      mem_cs[wr_ptr]  <= cs;
      mem_ip[wr_ptr]  <= ip;
    end
  end

  assign umi_adr_o = adr;
  assign umi_by_o  = by;
  assign umi_stb_o = stb;
  assign q_valid_o = (count != '0);
  assign q_dat_o   = mem_dat[rd_ptr];
  assign q_by_o    = mem_by[rd_ptr];
  assign q_cs_o    = mem_cs[rd_ptr];
  assign q_ip_o    = mem_ip[rd_ptr];
  assign level_o   = count;

endmodule

// File: tb/tb_zet_front_prefetch_umi_q.sv
// tb/tb_zet_front_prefetch_umi_q.sv - directed self-checking bench for zet_front_prefetch_umi_q
module tb_zet_front_prefetch_umi_q;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] umi_adr_o;
  logic [15:0] umi_dat_i;
  logic        umi_stb_o;
  logic        umi_by_o;
  logic        umi_ack_i;
  logic        flush;
  logic        load_cs_ip;
  logic [15:0] requested_cs;
  logic [15:0] requested_ip;
  logic        q_valid_o;
  logic [15:0] q_dat_o;
  logic        q_by_o;
  logic [15:0] q_cs_o;
  logic [15:0] q_ip_o;
  logic        q_rd_i;
  logic [2:0]  level_o;

  logic        auto_ack;
  logic        ack_man;
  logic [20:0] log_q[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  // Memory model: upper byte is never zero so byte masking is visible.
  function automatic logic [15:0] dat_of(input logic [19:0] a);
    return {a[7:0] ^ 8'ha5, a[7:0]};
  endfunction

  assign umi_ack_i = auto_ack ? umi_stb_o : ack_man;
  assign umi_dat_i = dat_of(umi_adr_o);

  always @(posedge clk)
    if (rst && umi_stb_o && umi_ack_i) log_q.push_back({umi_by_o, umi_adr_o});

  zet_front_prefetch_umi_q dut (
    .clk(clk), .rst(rst),
    .umi_adr_o(umi_adr_o), .umi_dat_i(umi_dat_i), .umi_stb_o(umi_stb_o),
    .umi_by_o(umi_by_o), .umi_ack_i(umi_ack_i),
    .flush(flush), .load_cs_ip(load_cs_ip),
    .requested_cs(requested_cs), .requested_ip(requested_ip),
    .q_valid_o(q_valid_o), .q_dat_o(q_dat_o), .q_by_o(q_by_o),
    .q_cs_o(q_cs_o), .q_ip_o(q_ip_o), .q_rd_i(q_rd_i), .level_o(level_o)
  );

  task automatic wait_full(input string name);
    int n = 0;
    while (!(level_o == 3'd4 && !umi_stb_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20) begin $display("FAIL %s_timeout level=%0d stb=%b want level 4 stb 0", name, level_o, umi_stb_o); fails++; end
  endtask

  task automatic wait_stb(input string name);
    int n = 0;
    while (!umi_stb_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 10) begin $display("FAIL %s_stb_timeout stb=%b want 1", name, umi_stb_o); fails++; end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++; if (umi_stb_o !== 1'b0) begin $display("FAIL rst_stb got %b want 0", umi_stb_o); fails++; end
    tests++; if (q_valid_o !== 1'b0) begin $display("FAIL rst_qvalid got %b want 0", q_valid_o); fails++; end
    tests++; if (level_o !== 3'd0) begin $display("FAIL rst_level got %0d want 0", level_o); fails++; end
    tests++; if (umi_adr_o !== 20'hffff0) begin $display("FAIL rst_adr got %h want ffff0", umi_adr_o); fails++; end
    tests++; if (umi_by_o !== 1'b0) begin $display("FAIL rst_by got %b want 0", umi_by_o); fails++; end
  endtask

  task automatic test_fill;
    log_q.delete();
    auto_ack = 1'b1;
    rst = 1'b1;
    wait_full("fill");
    tests++; if (log_q.size() != 4) begin $display("FAIL fill_count got %0d want 4", log_q.size()); fails++; end
    else begin
      tests++; if (log_q[0] !== 21'h0ffff0) begin $display("FAIL fill_adr0 got %h want 0ffff0", log_q[0]); fails++; end
      tests++; if (log_q[1] !== 21'h0ffff2) begin $display("FAIL fill_adr1 got %h want 0ffff2", log_q[1]); fails++; end
      tests++; if (log_q[2] !== 21'h0ffff4) begin $display("FAIL fill_adr2 got %h want 0ffff4", log_q[2]); fails++; end
      tests++; if (log_q[3] !== 21'h0ffff6) begin $display("FAIL fill_adr3 got %h want 0ffff6", log_q[3]); fails++; end
    end
    tests++; if (q_ip_o !== 16'hfff0) begin $display("FAIL fill_qip got %h want fff0", q_ip_o); fails++; end
    tests++; if (q_cs_o !== 16'hf000) begin $display("FAIL fill_qcs got %h want f000", q_cs_o); fails++; end
    tests++; if (q_dat_o !== 16'h55f0) begin $display("FAIL fill_qdat got %h want 55f0", q_dat_o); fails++; end
    tests++; if (q_by_o !== 1'b0) begin $display("FAIL fill_qby got %b want 0", q_by_o); fails++; end
  endtask

  task automatic test_pop_refill;
    auto_ack = 1'b0;
    q_rd_i = 1'b1;
    @(negedge clk);
    q_rd_i = 1'b0;
    tests++; if (level_o !== 3'd3) begin $display("FAIL pop_level got %0d want 3", level_o); fails++; end
    tests++; if (q_ip_o !== 16'hfff2) begin $display("FAIL pop_qip got %h want fff2", q_ip_o); fails++; end
    wait_stb("pop");
    tests++; if (umi_adr_o !== 20'hffff8) begin $display("FAIL refill_adr got %h want ffff8", umi_adr_o); fails++; end
    ack_man = 1'b1; q_rd_i = 1'b1;
    @(negedge clk);
    ack_man = 1'b0; q_rd_i = 1'b0;
    tests++; if (level_o !== 3'd3) begin $display("FAIL pushpop_level got %0d want 3", level_o); fails++; end
    tests++; if (umi_stb_o !== 1'b1) begin $display("FAIL pushpop_stb got %b want 1", umi_stb_o); fails++; end
    tests++; if (umi_adr_o !== 20'hffffa) begin $display("FAIL pushpop_adr got %h want ffffa", umi_adr_o); fails++; end
    tests++; if (q_ip_o !== 16'hfff4) begin $display("FAIL pushpop_qip got %h want fff4", q_ip_o); fails++; end
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    tests++; if (level_o !== 3'd4) begin $display("FAIL refull_level got %0d want 4", level_o); fails++; end
    tests++; if (umi_stb_o !== 1'b0) begin $display("FAIL refull_stb got %b want 0", umi_stb_o); fails++; end
  endtask

  task automatic test_redirect_byte;
    log_q.delete();
    auto_ack = 1'b1;
    load_cs_ip = 1'b1; requested_cs = 16'h1000; requested_ip = 16'h0003;
    @(negedge clk);
    load_cs_ip = 1'b0;
    tests++; if (level_o !== 3'd0 || q_valid_o !== 1'b0) begin $display("FAIL redir_empty got level %0d valid %b want 0 0", level_o, q_valid_o); fails++; end
    wait_full("redir");
    tests++; if (log_q.size() != 4) begin $display("FAIL redir_count got %0d want 4", log_q.size()); fails++; end
    else begin
      tests++; if (log_q[0] !== 21'h110003) begin $display("FAIL redir_adr0 got %h want 110003", log_q[0]); fails++; end
      tests++; if (log_q[1] !== 21'h010004) begin $display("FAIL redir_adr1 got %h want 010004", log_q[1]); fails++; end
      tests++; if (log_q[2] !== 21'h010006) begin $display("FAIL redir_adr2 got %h want 010006", log_q[2]); fails++; end
    end
    tests++; if (q_by_o !== 1'b1) begin $display("FAIL redir_qby got %b want 1", q_by_o); fails++; end
    tests++; if (q_dat_o !== 16'h0003) begin $display("FAIL redir_qdat got %h want 0003", q_dat_o); fails++; end
    tests++; if (q_ip_o !== 16'h0003 || q_cs_o !== 16'h1000) begin $display("FAIL redir_tag got %h:%h want 1000:0003", q_cs_o, q_ip_o); fails++; end
  endtask

  task automatic test_flush_drain;
    auto_ack = 1'b0;
    q_rd_i = 1'b1;
    @(negedge clk);
    q_rd_i = 1'b0;
    wait_stb("drain");
    tests++; if (umi_adr_o !== 20'h1000a) begin $display("FAIL drain_adr_pre got %h want 1000a", umi_adr_o); fails++; end
    flush = 1'b1; requested_cs = 16'h2000; requested_ip = 16'h0100;
    @(negedge clk);
    flush = 1'b0;
    tests++; if (umi_stb_o !== 1'b1 || umi_adr_o !== 20'h1000a) begin $display("FAIL drain_hold got stb %b adr %h want 1 1000a", umi_stb_o, umi_adr_o); fails++; end
    tests++; if (level_o !== 3'd0) begin $display("FAIL drain_level got %0d want 0", level_o); fails++; end
    repeat (2) @(negedge clk);
    tests++; if (umi_stb_o !== 1'b1 || umi_adr_o !== 20'h1000a) begin $display("FAIL drain_hold2 got stb %b adr %h want 1 1000a", umi_stb_o, umi_adr_o); fails++; end
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    tests++; if (umi_stb_o !== 1'b0 || level_o !== 3'd0) begin $display("FAIL drain_done got stb %b level %0d want 0 0", umi_stb_o, level_o); fails++; end
    @(negedge clk);
    tests++; if (umi_stb_o !== 1'b1 || umi_adr_o !== 20'h20100 || umi_by_o !== 1'b0) begin $display("FAIL drain_next got stb %b adr %h by %b want 1 20100 0", umi_stb_o, umi_adr_o, umi_by_o); fails++; end
  endtask

  task automatic test_wrap;
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    tests++; if (level_o !== 3'd1 || umi_adr_o !== 20'h20102) begin $display("FAIL wrap_pre got level %0d adr %h want 1 20102", level_o, umi_adr_o); fails++; end
    ack_man = 1'b1; load_cs_ip = 1'b1; requested_cs = 16'h3000; requested_ip = 16'hfffe;
    @(negedge clk);
    ack_man = 1'b0; load_cs_ip = 1'b0;
    tests++; if (level_o !== 3'd0 || umi_stb_o !== 1'b0) begin $display("FAIL ackredir got level %0d stb %b want 0 0", level_o, umi_stb_o); fails++; end
    @(negedge clk);
    tests++; if (umi_stb_o !== 1'b1 || umi_adr_o !== 20'h3fffe || umi_by_o !== 1'b0) begin $display("FAIL wrap_fetch got stb %b adr %h by %b want 1 3fffe 0", umi_stb_o, umi_adr_o, umi_by_o); fails++; end
    ack_man = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    tests++; if (q_ip_o !== 16'hfffe || q_cs_o !== 16'h3000 || q_dat_o !== 16'h5bfe) begin $display("FAIL wrap_head got %h:%h dat %h want 3000:fffe 5bfe", q_cs_o, q_ip_o, q_dat_o); fails++; end
    tests++; if (umi_adr_o !== 20'h30000 || umi_stb_o !== 1'b1) begin $display("FAIL wrap_adr got %h stb %b want 30000 1", umi_adr_o, umi_stb_o); fails++; end
  endtask

  task automatic test_reset_mid_fetch;
    #2;
    rst = 1'b0;
    #1;
    tests++; if (umi_stb_o !== 1'b0) begin $display("FAIL arst_stb got %b want 0", umi_stb_o); fails++; end
    tests++; if (level_o !== 3'd0 || q_valid_o !== 1'b0) begin $display("FAIL arst_q got level %0d valid %b want 0 0", level_o, q_valid_o); fails++; end
    tests++; if (umi_adr_o !== 20'hffff0) begin $display("FAIL arst_adr got %h want ffff0", umi_adr_o); fails++; end
    @(negedge clk);
    ack_man = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ack_man = 1'b0;
    tests++; if (level_o !== 3'd0 || umi_stb_o !== 1'b1 || umi_adr_o !== 20'hffff0) begin $display("FAIL stray_ack got level %0d stb %b adr %h want 0 1 ffff0", level_o, umi_stb_o, umi_adr_o); fails++; end
    log_q.delete();
    auto_ack = 1'b1;
    wait_full("restart");
    tests++; if (log_q.size() < 1 || log_q[0] !== 21'h0ffff0) begin $display("FAIL restart_adr got %h want 0ffff0", log_q.size() ? log_q[0] : 21'h0); fails++; end
    tests++; if (q_ip_o !== 16'hfff0) begin $display("FAIL restart_qip got %h want fff0", q_ip_o); fails++; end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; load_cs_ip = 1'b0;
    requested_cs = 16'h0; requested_ip = 16'h0;
    q_rd_i = 1'b0; auto_ack = 1'b0; ack_man = 1'b0;
    test_reset;
    test_fill;
    test_pop_refill;
    test_redirect_byte;
    test_flush_drain;
    test_wrap;
    test_reset_mid_fetch;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
